synth_seq: RTL and testbench

- Step sequencer that drives the `synth` voice's `trig` and `osc_count` inputs from a small writable pattern memory.
- Sits between the host/config side and `synth`; the ADSR and filter config ports of `synth` are wired straight through, not driven here.
- Provides tempo (`step_len`), gate length, rests, ties and loop length, so the voice plays patterns without host timing involvement.

---
 rtl/synth_pkg.sv | 34 +++
 rtl/synth_seq_if.sv | 23 ++
 rtl/synth_seq_timer.sv | 92 +++++++++
 rtl/synth_seq.sv | 164 ++++++++++++++++
 tb/tb_synth_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// synth_pkg -- shared definitions for the synth step sequencer.
//
// Contents:
//   seq_state_t   sequencer FSM states (IDLE, RUN)
//   MIN_STEP_LEN  shortest step in clocks; shorter step_len values are raised to it
//   NOTE_LSB      bit offset of the note field inside a pattern entry
//   entry_w()     pattern entry width for a given note width
//   note_on_bit() bit index of the note_on flag
//   tie_bit()     bit index of the tie flag
//
// Entry layout: [NOTE_W+1] = note_on, [NOTE_W] = tie, [NOTE_W-1:0] = note.
package synth_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

   localparam int MIN_STEP_LEN = 2;
   localparam int NOTE_LSB     = 0;

   function automatic int entry_w(input int note_w);
      return note_w + 2;
   endfunction

   function automatic int note_on_bit(input int note_w);
      return note_w + 1;
   endfunction

   function automatic int tie_bit(input int note_w);
      return note_w;
   endfunction

endpackage

// File: rtl/synth_seq_if.sv
// synth_seq_if -- pattern-memory write bus of the step sequencer.
//
// Parameters:
//   AW  pattern address width
//   EW  pattern entry width (note_on, tie, note)
// Signals:
//   wr_en    write strobe, one entry per cycle
//   wr_addr  entry index
//   wr_data  entry contents
// Modports:
//   master  host side, drives the bus
//   slave   sequencer side, receives the bus
interface synth_seq_if #(
   parameter int AW = 4,
   parameter int EW = 10
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [EW-1:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/synth_seq_timer.sv
// synth_seq_timer -- step/gate cycle counter of the step sequencer.
//
// Counts clocks inside the current step and tells the sequencer when the
// step is over and when the gate should close.
//
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   restart      a new step starts next cycle (counter returns to 0)
//   enable       sequencer keeps running next cycle
//   step_len     clocks per step (values below 2 act as 2)
//   gate_len     clocks of gate per note (clamped to step length - 1, at least 1)
//   swing        (SYNTH_SEQ_SWING_EN only) swing amount in sixteenths of a step
//   odd_step     (SYNTH_SEQ_SWING_EN only) current step index is odd
//   step_end     current cycle is the last one of the step
//   gate_end     gate must be low from the next cycle on
//
// Macro SYNTH_SEQ_SWING_EN: even steps are stretched and odd steps shortened
// by swing*eff_len/16 clocks, keeping the pair period constant.
module synth_seq_timer
   import synth_pkg::*;
#(
   parameter int CNT_W = 24
)(
   input  logic             clk,
   input  logic             rstn,
   input  logic             restart,
   input  logic             enable,
   input  logic [CNT_W-1:0] step_len,
   input  logic [CNT_W-1:0] gate_len,
`ifdef SYNTH_SEQ_SWING_EN
   input  logic [3:0]       swing,
   input  logic             odd_step,
`endif
   output logic             step_end,
   output logic             gate_end
);

   // One extra bit so a swing-stretched even step cannot overflow.
   localparam int LW = CNT_W + 1;

   logic [LW-1:0] cnt_reg;
   logic [LW-1:0] cnt_next;
   logic [LW-1:0] eff_len;
   logic [LW-1:0] cur_len;
   logic [LW-1:0] gate_w;
   logic [LW-1:0] eff_gate;

   assign eff_len = (step_len < CNT_W'(MIN_STEP_LEN)) ? LW'(MIN_STEP_LEN) : LW'(step_len);
   assign gate_w  = LW'(gate_len);

`ifdef SYNTH_SEQ_SWING_EN
   localparam int PW = LW + 4;
   logic [PW-1:0] swing_prod;
   logic [LW-1:0] swing_off;

   assign swing_prod = PW'(swing) * PW'(eff_len);
   assign swing_off  = swing_prod[PW-1:4];
   assign cur_len    = odd_step ? (eff_len - swing_off) : (eff_len + swing_off);
`else
   assign cur_len = eff_len;
`endif

   // Gate never reaches the final cycle of a step, so an untied note always
   // drops before the next step; a zero gate still yields one trig cycle.
   always_comb begin
      eff_gate = (gate_w > cur_len - LW'(1)) ? cur_len - LW'(1) : gate_w;
      if (eff_gate == '0) begin
         eff_gate = LW'(1);
      end
   end

   // '>=' rather than '==' so a step_len/gate_len cut below the current
   // count still ends the step / closes the gate on the next cycle.
   assign step_end = (cnt_reg >= cur_len - LW'(1));
   assign gate_end = (cnt_reg + LW'(1) >= eff_gate);

   always_comb begin
      cnt_next = '0;
      if (!restart && enable) begin
         cnt_next = cnt_reg + LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/synth_seq.sv
// synth_seq -- step sequencer driving the trig/osc_count inputs of synth.
//
// Ports:
//   clk, rstn    clock, synchronous active-low reset (also clears the pattern)
//   run          level: high plays, low stops
//   step_len     clocks per step
//   gate_len     clocks trig stays high per note
//   last_step    loop end index, inclusive
//   swing        (SYNTH_SEQ_SWING_EN only) odd-step delay in sixteenths of a step
//   wr           pattern write bus (synth_seq_if slave)
//   trig         gate to synth.trig
//   osc_count    pitch to synth.osc_count
//   step         index of the playing step
//   step_pulse   one-cycle strobe in the first cycle of every step
//   running      high while playing
//
// Macro SYNTH_SEQ_SWING_EN adds the swing input.
module synth_seq
   import synth_pkg::*;
#(
   parameter  int NSTEPS = 16,
   parameter  int CNT_W  = 24,
   parameter  int NOTE_W = 8,
   localparam int AW     = $clog2(NSTEPS)
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              run,
   input  logic [CNT_W-1:0]  step_len,
   input  logic [CNT_W-1:0]  gate_len,
   input  logic [AW-1:0]     last_step,
`ifdef SYNTH_SEQ_SWING_EN
   input  logic [3:0]        swing,
`endif
   synth_seq_if.slave        wr,
   output logic              trig,
   output logic [NOTE_W-1:0] osc_count,
   output logic [AW-1:0]     step,
   output logic              step_pulse,
   output logic              running
);

   localparam int EW          = entry_w(NOTE_W);
   localparam int NOTE_ON_BIT = note_on_bit(NOTE_W);
   localparam int TIE_BIT     = tie_bit(NOTE_W);

   logic [EW-1:0]     mem [NSTEPS];

   seq_state_t        state_reg, state_next;
   logic [AW-1:0]     step_reg, step_next;
   logic [NOTE_W-1:0] osc_reg, osc_next;
   logic              trig_reg, trig_next;
   logic              pulse_reg, pulse_next;
   logic              tie_reg, tie_next;     // current step is a tied note

   logic [AW-1:0]     wrap_addr;
   logic [AW-1:0]     rd_addr;
   logic [EW-1:0]     rd_entry;
   logic              load;
   logic              step_end;
   logic              gate_end;

   // Address of the step that would start next; a start from IDLE is always step 0.
   assign wrap_addr = (step_reg >= last_step) ? '0 : step_reg + AW'(1);
   assign rd_addr   = (state_reg == IDLE) ? '0 : wrap_addr;
   // Sampled into the step registers on the boundary edge, so a write landing
   // on that same edge is seen only on the next pass.
   assign rd_entry  = mem[rd_addr];

   synth_seq_timer #(
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rstn     (rstn),
      .restart  (load),
      .enable   ((state_reg == RUN) && run),
      .step_len (step_len),
      .gate_len (gate_len),
`ifdef SYNTH_SEQ_SWING_EN
      .swing    (swing),
      .odd_step (step_reg[0]),
`endif
      .step_end (step_end),
      .gate_end (gate_end)
   );

   always_comb begin
      state_next = state_reg;
      step_next  = step_reg;
      osc_next   = osc_reg;
      trig_next  = trig_reg;
      pulse_next = 1'b0;
      tie_next   = tie_reg;
      load       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (run) begin
               state_next = RUN;
               load       = 1'b1;
            end
         end
         RUN: begin
            if (!run) begin
               state_next = IDLE;
               trig_next  = 1'b0;
               tie_next   = 1'b0;
            end else if (step_end) begin
               load = 1'b1;
            end else if (gate_end) begin
               // A tied note keeps the gate open to the end of its step.
               trig_next = tie_reg;
            end
         end
         default: state_next = IDLE;
      endcase

      if (load) begin
         step_next  = rd_addr;
         pulse_next = 1'b1;
         // A tie from the previous step holds trig through this step's gate.
         trig_next  = rd_entry[NOTE_ON_BIT] | ((state_reg == RUN) && tie_reg);
         tie_next   = rd_entry[NOTE_ON_BIT] & rd_entry[TIE_BIT];
         if (rd_entry[NOTE_ON_BIT]) begin
            osc_next = rd_entry[NOTE_LSB +: NOTE_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg <= IDLE;
         step_reg  <= '0;
         osc_reg   <= '0;
         trig_reg  <= 1'b0;
         pulse_reg <= 1'b0;
         tie_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         step_reg  <= step_next;
         osc_reg   <= osc_next;
         trig_reg  <= trig_next;
         pulse_reg <= pulse_next;
         tie_reg   <= tie_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NSTEPS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr.wr_en) begin
         mem[wr.wr_addr] <= wr.wr_data;
      end
   end

   assign trig       = trig_reg;
   assign osc_count  = osc_reg;
   assign step       = step_reg;
   assign step_pulse = pulse_reg;
   assign running    = (state_reg == RUN);

endmodule

// File: tb/tb_synth_seq.sv
// tb_synth_seq -- self-checking bench for synth_seq.
//
// The stimulus side computes, per step, what the sequencer must show (index,
// pitch, trig at the step start, step length, trig-high cycles) from the
// pattern and timing settings and queues it; an independent monitor checks
// each step as the DUT announces it with step_pulse.
// Works with or without SYNTH_SEQ_SWING_EN.
module tb_synth_seq;

   localparam int NSTEPS = 16;
   localparam int CNT_W  = 24;
   localparam int NOTE_W = 8;
   localparam int AW     = 4;
   localparam int EW     = NOTE_W + 2;

   typedef struct {
      int idx;
      int osc;
      int trig;
      int len;
      int high;
   } exp_t;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              run = 1'b0;
   logic [CNT_W-1:0]  step_len = 10;
   logic [CNT_W-1:0]  gate_len = 4;
   logic [AW-1:0]     last_step = '0;
   logic              trig;
   logic [NOTE_W-1:0] osc_count;
   logic [AW-1:0]     step;
   logic              step_pulse;
   logic              running;
`ifdef SYNTH_SEQ_SWING_EN
   logic [3:0]        swing_in = '0;
`endif

   synth_seq_if #(.AW(AW), .EW(EW)) wr_if ();

   synth_seq #(
      .NSTEPS     (NSTEPS),
      .CNT_W      (CNT_W),
      .NOTE_W     (NOTE_W)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .run        (run),
      .step_len   (step_len),
      .gate_len   (gate_len),
      .last_step  (last_step),
`ifdef SYNTH_SEQ_SWING_EN
      .swing      (swing_in),
`endif
      .wr         (wr_if),
      .trig       (trig),
      .osc_count  (osc_count),
      .step       (step),
      .step_pulse (step_pulse),
      .running    (running)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   exp_t          exp_q[$];
   logic [EW-1:0] pat [NSTEPS];

   // reference model state
   int m_idx = 0;
   int m_osc = 0;
   int m_carry = 0;
   int m_last_len = 0;
   int m_last_idx = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int step_cycles(input int idx);
      int el;
      el = (int'(step_len) < 2) ? 2 : int'(step_len);
`ifdef SYNTH_SEQ_SWING_EN
      begin
         int off;
         off = int'(swing_in) * el / 16;
         el  = (idx % 2 == 1) ? el - off : el + off;
      end
`else
      if (idx < 0) el = 0;
`endif
      return el;
   endfunction

   task automatic model_step();
      exp_t          e;
      logic [EW-1:0] ent;
      int            on, tie, len, g;
      ent = pat[m_idx];
      on  = int'(ent[EW-1]);
      tie = int'(ent[EW-2]);
      len = step_cycles(m_idx);
      g   = (int'(gate_len) < len - 1) ? int'(gate_len) : len - 1;
      if (g < 1) g = 1;
      if (on != 0) m_osc = int'(ent[NOTE_W-1:0]);
      e.idx  = m_idx;
      e.osc  = m_osc;
      e.trig = (on != 0 || m_carry != 0) ? 1 : 0;
      e.len  = len;
      if (on != 0 && tie != 0)       e.high = len;
      else if (on != 0 || m_carry != 0) e.high = g;
      else                           e.high = 0;
      exp_q.push_back(e);
      m_last_len = len;
      m_last_idx = m_idx;
      m_carry    = (on != 0 && tie != 0) ? 1 : 0;
      m_idx      = (m_idx >= int'(last_step)) ? 0 : m_idx + 1;
   endtask

   task automatic write_pattern();
      for (int i = 0; i < NSTEPS; i++) begin
         @(negedge clk);
         wr_if.wr_en   = 1'b1;
         wr_if.wr_addr = AW'(i);
         wr_if.wr_data = pat[i];
      end
      @(negedge clk);
      wr_if.wr_en = 1'b0;
   endtask

   // Play n steps, stop stop_cnt cycles into the last one; optionally rewrite
   // entry 1 on the very edge that loads step 1 the first time.
   task automatic play(input int n, input int stop_cnt, input bit do_write,
                       input bit coll, input logic [EW-1:0] coll_data);
      int pulses, since, cyc, first_len, sc;
      first_len = 2;
      if (do_write) write_pattern();
      m_idx   = 0;
      m_carry = 0;
      for (int k = 0; k < n; k++) begin
         model_step();
         if (k == 0) first_len = m_last_len;
         if (coll && k == 1) pat[1] = coll_data;
      end
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      check("start_pulse", int'(step_pulse), 1);
      check("start_step", int'(step), 0);
      check("start_running", int'(running), 1);
      pulses = 1;
      since  = 0;
      cyc    = 0;
      while (pulses < n && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         since++;
         if (step_pulse) begin
            pulses++;
            since = 0;
         end
         if (coll && pulses == 1 && since == first_len - 1) begin
            wr_if.wr_en   = 1'b1;
            wr_if.wr_addr = AW'(1);
            wr_if.wr_data = coll_data;
         end else begin
            wr_if.wr_en = 1'b0;
         end
      end
      wr_if.wr_en = 1'b0;
      check("pulse_count", pulses, n);
      sc = (stop_cnt < m_last_len - 1) ? stop_cnt : m_last_len - 1;
      repeat (sc) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      check("stop_running", int'(running), 0);
      check("stop_trig", int'(trig), 0);
      check("stop_step", int'(step), m_last_idx);
      check("stop_osc", int'(osc_count), m_osc);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: one expected entry per step_pulse; the step's length and
   // trig-high count are checked when the following step starts.
   initial begin
      exp_t cur;
      bit   have;
      int   len_c, hi_c;
      have  = 1'b0;
      len_c = 0;
      hi_c  = 0;
      forever begin
         @(negedge clk);
         if (!running) begin
            have = 1'b0;
         end else if (step_pulse) begin
            if (have) begin
               check("step_cycles", len_c, cur.len);
               check("trig_high_cycles", hi_c, cur.high);
            end
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_step: got step %0d expected no step", step);
               have = 1'b0;
            end else begin
               cur = exp_q.pop_front();
               check("step_index", int'(step), cur.idx);
               check("step_osc", int'(osc_count), cur.osc);
               check("step_trig", int'(trig), cur.trig);
               $display("step %0d osc=%0d trig=%0d", step, osc_count, trig);
               have  = 1'b1;
               len_c = 1;
               hi_c  = int'(trig);
            end
         end else begin
            len_c++;
            hi_c += int'(trig);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [EW-1:0] e;
      wr_if.wr_en   = 1'b0;
      wr_if.wr_addr = '0;
      wr_if.wr_data = '0;
      for (int i = 0; i < NSTEPS; i++) pat[i] = '0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_trig", int'(trig), 0);
      check("rst_osc", int'(osc_count), 0);
      check("rst_step", int'(step), 0);
      check("rst_pulse", int'(step_pulse), 0);
      check("rst_running", int'(running), 0);
      rstn = 1'b1;
      @(negedge clk);
      check("idle_running", int'(running), 0);

      // basic pattern with a rest, wrap 3 -> 0
      pat[0] = {2'b10, 8'd66};
      pat[1] = {2'b10, 8'd80};
      pat[2] = {2'b00, 8'd12};
      pat[3] = {2'b10, 8'd40};
      last_step = 3;
      step_len  = 10;
      gate_len  = 4;
      play(6, 3, 1'b1, 1'b0, '0);

      // stop at count 5 of step 2, then restart at step 0
      play(3, 5, 1'b0, 1'b0, '0);

      // gate longer than the step: clamps to leave one low cycle
      pat[0] = {2'b10, 8'd50};
      pat[1] = {2'b10, 8'd90};
      last_step = 1;
      gate_len  = 20;
      play(4, 2, 1'b1, 1'b0, '0);

      // tie into a note (legato), then tie into a rest
      pat[0] = {2'b11, 8'd66};
      pat[1] = {2'b10, 8'd80};
      gate_len = 3;
      play(4, 2, 1'b1, 1'b0, '0);
      pat[1] = {2'b11, 8'd81};
      pat[2] = {2'b00, 8'd7};
      last_step = 2;
      play(5, 1, 1'b1, 1'b0, '0);

      // write colliding with the load of step 1
      pat[0] = {2'b10, 8'd66};
      pat[1] = {2'b10, 8'd80};
      pat[2] = {2'b00, 8'd0};
      pat[3] = {2'b10, 8'd40};
      last_step = 3;
      step_len  = 10;
      gate_len  = 4;
      play(7, 1, 1'b1, 1'b1, {2'b10, 8'd99});

      // reset in the middle of a step clears outputs and pattern
      write_pattern();
      m_idx   = 0;
      m_carry = 0;
      model_step();
      @(negedge clk);
      run = 1'b1;
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      run  = 1'b0;
      @(negedge clk);
      check("midrst_trig", int'(trig), 0);
      check("midrst_osc", int'(osc_count), 0);
      check("midrst_step", int'(step), 0);
      check("midrst_pulse", int'(step_pulse), 0);
      check("midrst_running", int'(running), 0);
      rstn = 1'b1;
      exp_q.delete();
      for (int i = 0; i < NSTEPS; i++) pat[i] = '0;
      m_osc = 0;
      play(4, 2, 1'b0, 1'b0, '0);

      // randomized segments
      for (int s = 0; s < 20; s++) begin
         for (int i = 0; i < NSTEPS; i++) begin
            e[EW-1]       = ($urandom_range(0, 3) != 0);
            e[EW-2]       = ($urandom_range(0, 2) == 0);
            e[NOTE_W-1:0] = NOTE_W'($urandom_range(0, 255));
            pat[i] = e;
         end
         last_step = AW'($urandom_range(0, NSTEPS - 1));
         step_len  = CNT_W'($urandom_range(0, 9));
         gate_len  = CNT_W'($urandom_range(0, 12));
         play(int'($urandom_range(3, 10)), int'($urandom_range(0, 8)), 1'b1, 1'b0, '0);
      end

`ifdef SYNTH_SEQ_SWING_EN
      // swing: steps start at 0, 24, 32, 56, ...
      pat[0] = {2'b10, 8'd60};
      pat[1] = {2'b10, 8'd62};
      pat[2] = {2'b10, 8'd64};
      pat[3] = {2'b10, 8'd65};
      last_step = 3;
      step_len  = 16;
      gate_len  = 4;
      swing_in  = 4'd8;
      play(6, 2, 1'b1, 1'b0, '0);
      swing_in  = 4'd0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
